// File: rtl/design_params_pkg.sv
// Shared timer-subsystem parameters plus the bus arbiter state type.
// The arbiter's optional slave-grant timeout is enabled by defining ARB_TIMEOUT_EN.
package design_params_pkg;

    localparam int P_ADDR_WIDTH = 8;
    localparam int P_DATA_WIDTH = 16;

    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_STATUS = 8'h04;
    localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_LOAD   = 8'h08;

    localparam int P_ARB_N_MASTERS = 2;
    localparam int P_ARB_TIMEOUT   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of a master index; never less than one bit.
    function automatic int arb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_rr_pick.sv
// Round-robin winner selection: first set request bit at or above rr_ptr,
// wrapping modulo N_MASTERS. Purely combinational.
module timer_rr_pick
    import design_params_pkg::*;
#(
    parameter int N_MASTERS = P_ARB_N_MASTERS,
    localparam int IDX_W    = arb_idx_width(N_MASTERS),
    localparam int IDX_W1   = IDX_W + 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    logic [IDX_W1-1:0] cand_s;

    // Scan candidates in priority order starting at rr_ptr; first hit wins.
    always_comb begin
        winner = {IDX_W{1'b0}};
        valid  = 1'b0;
        cand_s = {IDX_W1{1'b0}};
        for (int i = 0; i < N_MASTERS; i++) begin
            cand_s = {1'b0, rr_ptr} + IDX_W1'(i);
            cand_s = (cand_s >= IDX_W1'(N_MASTERS)) ? (cand_s - IDX_W1'(N_MASTERS)) : cand_s;
            if (!valid && req[cand_s[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand_s[IDX_W-1:0];
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the timer register bus between N_MASTERS masters.
// Every grant yields one clean slave transaction with at least two idle s_req
// cycles in between. Optional slave-grant timeout: define ARB_TIMEOUT_EN.
module timer_bus_arbiter
    import design_params_pkg::*;
#(
    parameter int N_MASTERS      = P_ARB_N_MASTERS,
    parameter int TIMEOUT_CYCLES = P_ARB_TIMEOUT,
    localparam int AW            = P_ADDR_WIDTH,
    localparam int DW            = P_DATA_WIDTH,
    localparam int IDX_W         = arb_idx_width(N_MASTERS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    input  logic [N_MASTERS-1:0]    m_write_en,
    output logic [N_MASTERS-1:0]    m_gnt,
    output logic [DW-1:0]           m_rdata,
    output logic                    m_err,
    output logic                    s_req,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    output logic                    s_write_en,
    input  logic                    s_gnt,
    input  logic [DW-1:0]           s_rdata
);

    arb_state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0]     owner_r, owner_nxt_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic                 s_req_r, s_req_nxt_s;
    logic [AW-1:0]        s_addr_r, s_addr_nxt_s;
    logic [DW-1:0]        s_wdata_r, s_wdata_nxt_s;
    logic                 s_we_r, s_we_nxt_s;
    logic [N_MASTERS-1:0] m_gnt_r, m_gnt_nxt_s;
    logic [DW-1:0]        m_rdata_r, m_rdata_nxt_s;
    logic                 m_err_r, m_err_nxt_s;
    logic [IDX_W-1:0]     pick_winner_s;
    logic                 pick_valid_s;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]           wait_cnt_r, wait_cnt_nxt_s;
`else
    logic                 unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    timer_rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .req    (m_req),
        .rr_ptr (rr_ptr_r),
        .winner (pick_winner_s),
        .valid  (pick_valid_s)
    );

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        s_req_nxt_s   = s_req_r;
        s_addr_nxt_s  = s_addr_r;
        s_wdata_nxt_s = s_wdata_r;
        s_we_nxt_s    = s_we_r;
        m_gnt_nxt_s   = {N_MASTERS{1'b0}};
        m_rdata_nxt_s = m_rdata_r;
        m_err_nxt_s   = m_err_r;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_nxt_s = wait_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s   = REQ;
                    owner_nxt_s   = pick_winner_s;
                    s_addr_nxt_s  = m_addr[pick_winner_s*AW +: AW];
                    s_wdata_nxt_s = m_wdata[pick_winner_s*DW +: DW];
                    s_we_nxt_s    = m_write_en[pick_winner_s];
                    s_req_nxt_s   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_nxt_s = 8'd0;
`endif
                end else begin
                    s_req_nxt_s = 1'b0;
                end
            end
            REQ: begin
                s_req_nxt_s = 1'b1;
                if (s_gnt) begin
                    state_nxt_s          = RESP;
                    s_req_nxt_s          = 1'b0;
                    m_gnt_nxt_s[owner_r] = 1'b1;
                    m_rdata_nxt_s        = s_we_r ? {DW{1'b0}} : s_rdata;
                    m_err_nxt_s          = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (wait_cnt_r == 8'(TIMEOUT_CYCLES - 32'sd1)) begin
                    state_nxt_s          = RESP;
                    s_req_nxt_s          = 1'b0;
                    m_gnt_nxt_s[owner_r] = 1'b1;
                    m_rdata_nxt_s        = {DW{1'b0}};
                    m_err_nxt_s          = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
`else
                end else begin
                    state_nxt_s = REQ;
                end
`endif
            end
            RESP: begin
                // Returning to IDLE rather than re-arbitrating keeps s_req low for two cycles.
                state_nxt_s  = IDLE;
                s_req_nxt_s  = 1'b0;
                rr_ptr_nxt_s = (owner_r == IDX_W'(N_MASTERS - 1)) ? {IDX_W{1'b0}}
                                                                  : (owner_r + IDX_W'(1'b1));
            end
            default: begin
                state_nxt_s = IDLE;
                s_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            owner_r   <= {IDX_W{1'b0}};
            rr_ptr_r  <= {IDX_W{1'b0}};
            s_req_r   <= 1'b0;
            s_addr_r  <= {AW{1'b0}};
            s_wdata_r <= {DW{1'b0}};
            s_we_r    <= 1'b0;
            m_gnt_r   <= {N_MASTERS{1'b0}};
            m_rdata_r <= {DW{1'b0}};
            m_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            s_req_r   <= s_req_nxt_s;
            s_addr_r  <= s_addr_nxt_s;
            s_wdata_r <= s_wdata_nxt_s;
            s_we_r    <= s_we_nxt_s;
            m_gnt_r   <= m_gnt_nxt_s;
            m_rdata_r <= m_rdata_nxt_s;
            m_err_r   <= m_err_nxt_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Slave-grant wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end
    assign m_err = m_err_r;
`else
    assign m_err = 1'b0;
`endif

    assign m_gnt      = m_gnt_r;
    assign m_rdata    = m_rdata_r;
    assign s_req      = s_req_r;
    assign s_addr     = s_addr_r;
    assign s_wdata    = s_wdata_r;
    assign s_write_en = s_we_r;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed, scoreboard-based bench for timer_bus_arbiter (2 masters).
// Timeout steps are compiled in when ARB_TIMEOUT_EN is defined.
module tb_timer_bus_arbiter;
    import design_params_pkg::*;

    localparam int N  = 2;
    localparam int AW = P_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    m_req = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_write_en = '0;
    logic [N-1:0]    m_gnt;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_write_en;
    logic            s_gnt = 1'b0;
    logic [DW-1:0]   s_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    exp_t sb[$];

    // slave model controls
    bit slv_enable = 1'b1;
    bit slv_force  = 1'b0;
    bit slv_fixed  = 1'b0;
    int slv_delay  = 1;
    int slv_cnt    = 0;
    logic [DW-1:0] slv_rdata = '0;

    // s_req monitor
    bit            mon_prev = 1'b0;
    int            mon_low = 0, mon_high = 0, mon_rises = 0, mon_min_gap = 99;
    bit            mon_bad = 1'b0;
    logic [AW-1:0] mon_addr;
    logic [DW-1:0] mon_wd;
    logic          mon_we;

    timer_bus_arbiter dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_write_en(m_write_en), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_write_en(s_write_en),
        .s_gnt(s_gnt), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Slave: grant slv_delay cycles after s_req rises; data is fixed or address-derived.
    always @(negedge clk) begin
        if (slv_force) begin
            s_gnt = 1'b1;
        end else if (s_req && slv_enable) begin
            s_gnt = (slv_cnt == slv_delay);
            slv_cnt++;
        end else begin
            s_gnt = 1'b0;
            slv_cnt = 0;
        end
        s_rdata = slv_fixed ? slv_rdata : {8'hA5, s_addr};
    end

    // Track s_req low gaps, high length and payload stability while high.
    always @(negedge clk) begin
        if (s_req) begin
            if (!mon_prev) begin
                if (mon_rises > 0 && mon_low < mon_min_gap) mon_min_gap = mon_low;
                mon_rises++;
                mon_addr = s_addr; mon_wd = s_wdata; mon_we = s_write_en;
                mon_high = 1;
            end else begin
                mon_high++;
                if (s_addr !== mon_addr || s_wdata !== mon_wd || s_write_en !== mon_we) mon_bad = 1'b1;
            end
            mon_low = 0;
        end else begin
            mon_low++;
        end
        mon_prev = s_req;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        mon_rises = 0; mon_min_gap = 99; mon_bad = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; m_req = '0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
        mon_clear();
    endtask

    task automatic wait_sreq(input string tag, input int max);
        bit got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (s_req) got = 1'b1;
        end
        check({tag, " sreq_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_gnt(input string tag, input int max);
        exp_t e;
        bit got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (m_gnt != '0) got = 1'b1;
        end
        check({tag, " gnt_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, " m_gnt"}, 32'(m_gnt), 32'(e.gnt));
                check({tag, " m_rdata"}, 32'(m_rdata), 32'(e.rdata));
                check({tag, " m_err"}, 32'(m_err), 32'(e.err));
            end
        end
    endtask

    initial begin
        int t0;

        // Reset values
        tick(); tick();
        check("rst s_req", 32'(s_req), 32'd0);
        check("rst m_gnt", 32'(m_gnt), 32'd0);
        check("rst m_rdata", 32'(m_rdata), 32'd0);
        check("rst m_err", 32'(m_err), 32'd0);
        check("rst s_payload", {15'd0, s_write_en, s_wdata}, 32'd0);
        check("rst s_addr", 32'(s_addr), 32'd0);
        reset = 1'b0;
        mon_clear();

        // Single read: grant two cycles after s_req, m_gnt four cycles after m_req
        m_addr[0*AW +: AW] = P_ADDR_STATUS;
        slv_fixed = 1'b1; slv_rdata = 16'h005A; slv_delay = 2;
        m_req = 2'b01; t0 = cyc;
        sb.push_back('{gnt: 2'b01, rdata: 16'h005A, err: 1'b0});
        wait_sreq("rd", 10);
        check("rd sreq_cycle", 32'(cyc - t0), 32'd1);
        check("rd s_addr", 32'(s_addr), 32'(P_ADDR_STATUS));
        wait_gnt("rd", 20);
        check("rd gnt_cycle", 32'(cyc - t0), 32'd4);
        m_req = 2'b00;

        // Contention from reset: grants alternate 01,10,01,10
        do_reset();
        slv_fixed = 1'b0; slv_delay = 1;
        m_addr[0*AW +: AW] = 8'h20;
        m_addr[1*AW +: AW] = 8'h31;
        m_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{gnt: (k % 2 == 0) ? 2'b01 : 2'b10,
                           rdata: (k % 2 == 0) ? 16'hA520 : 16'hA531, err: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            wait_gnt("cont", 20);
            if (k == 3) m_req = 2'b00;
        end
        tick();
        check("cont rises", 32'(mon_rises), 32'd4);
        check("cont min_gap_ge2", 32'(mon_min_gap >= 2), 32'd1);

        // Reset mid-transaction, then master 1 wins first after release
        do_reset();
        slv_enable = 1'b0;
        m_req = 2'b01;
        wait_sreq("rstmid", 10);
        tick();
        reset = 1'b1;
        #1;
        check("rstmid s_req", 32'(s_req), 32'd0);
        check("rstmid m_gnt", 32'(m_gnt), 32'd0);
        m_req = 2'b10;
        tick(); tick();
        slv_enable = 1'b1; slv_delay = 1;
        reset = 1'b0; t0 = cyc;
        sb.delete();
        sb.push_back('{gnt: 2'b10, rdata: 16'hA531, err: 1'b0});
        wait_gnt("rstmid", 20);
        check("rstmid gnt_cycle", 32'(cyc - t0), 32'd3);
        m_req = 2'b00;
        tick();

        // Write pass-through from master 1
        mon_clear();
        m_addr[1*AW +: AW] = P_ADDR_LOAD;
        m_wdata[1*DW +: DW] = 16'h1234;
        m_write_en = 2'b10;
        m_wdata[0*DW +: DW] = 16'hDEAD;
        slv_fixed = 1'b1; slv_rdata = 16'hBEEF; slv_delay = 3;
        m_req = 2'b10;
        sb.push_back('{gnt: 2'b10, rdata: 16'h0000, err: 1'b0});
        wait_sreq("wr", 10);
        check("wr s_write_en", 32'(s_write_en), 32'd1);
        check("wr s_wdata", 32'(s_wdata), 32'h1234);
        check("wr s_addr", 32'(s_addr), 32'(P_ADDR_LOAD));
        wait_gnt("wr", 20);
        m_req = 2'b00; m_write_en = 2'b00;
        check("wr payload_stable", 32'(mon_bad), 32'd0);
        tick();

        // Payload stability: master 0 changes inputs during REQ
        mon_clear();
        slv_fixed = 1'b0; slv_delay = 4;
        m_addr[0*AW +: AW] = 8'h10;
        m_req = 2'b01;
        sb.push_back('{gnt: 2'b01, rdata: 16'hA510, err: 1'b0});
        wait_sreq("stab", 10);
        m_addr[0*AW +: AW] = 8'hFF;
        m_wdata[0*DW +: DW] = 16'hFFFF;
        m_write_en = 2'b01;
        tick();
        check("stab s_addr", 32'(s_addr), 32'h10);
        check("stab s_write_en", 32'(s_write_en), 32'd0);
        wait_gnt("stab", 20);
        m_req = 2'b00; m_write_en = 2'b00;
        check("stab payload_stable", 32'(mon_bad), 32'd0);

        // Spurious s_gnt while idle is ignored; m_rdata holds
        tick();
        slv_force = 1'b1;
        tick(); tick(); tick();
        check("spur m_gnt", 32'(m_gnt), 32'd0);
        check("spur s_req", 32'(s_req), 32'd0);
        slv_force = 1'b0;
        tick();
        check("spur m_rdata_hold", 32'(m_rdata), 32'hA510);

`ifdef ARB_TIMEOUT_EN
        // Timeout: slave never grants
        mon_clear();
        slv_enable = 1'b0;
        m_addr[1*AW +: AW] = 8'h44;
        m_req = 2'b10;
        sb.push_back('{gnt: 2'b10, rdata: 16'h0000, err: 1'b1});
        wait_gnt("tmo", 40);
        m_req = 2'b00;
        check("tmo sreq_len", 32'(mon_high), 32'd8);
        slv_enable = 1'b1;
        tick();
`endif

        check("sb drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
- Shares the single timer register bus (req/gnt handshake, addr/wdata/write_en/rdata) between N_MASTERS requesters.
- Uses round-robin arbitration. Sits between the masters (CPU, DMA, test port) and the timer slave.
- Guarantees a clean, protocol-correct slave transaction per grant:
  - one s_req rising edge per transaction;
  - s_req held until s_gnt;
  - a mandatory idle cycle between transactions.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 8, slave-grant wait limit in cycles; used only with the optional feature.
- P_ADDR_WIDTH, from design_params_pkg, address width.
- P_DATA_WIDTH, from design_params_pkg, data width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  N_MASTERS  per-master request; held high until that master's m_gnt.
- m_addr  in  N_MASTERS*P_ADDR_WIDTH  flattened per-master address; master i at slice [i*P_ADDR_WIDTH +: P_ADDR_WIDTH].
- m_wdata  in  N_MASTERS*P_DATA_WIDTH  flattened per-master write data.
- m_write_en  in  N_MASTERS  per-master write enable (1 = write, 0 = read).
- m_gnt  out  N_MASTERS  one-cycle completion pulse to the owning master.
- m_rdata  out  P_DATA_WIDTH  read data; valid in the m_gnt cycle.
- m_err  out  1  timeout error flag; valid in the m_gnt cycle.
- s_req  out  1  request to the timer slave.
- s_addr  out  P_ADDR_WIDTH  slave address.
- s_wdata  out  P_DATA_WIDTH  slave write data.
- s_write_en  out  1  slave write enable.
- s_gnt  in  1  slave grant.
- s_rdata  in  P_DATA_WIDTH  slave read data; valid with s_gnt.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state=IDLE, owner=0, rr_ptr=0.
  - s_req, s_addr, s_wdata, s_write_en, m_gnt, m_rdata, m_err all 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If m_req != 0, pick the winner: first set bit searching from rr_ptr upward, wrapping modulo N_MASTERS.
  - Register owner, latch the owner's addr/wdata/write_en into s_addr/s_wdata/s_write_en, set s_req=1, go to REQ.
  - If m_req == 0, stay in IDLE with s_req=0.
- REQ:
  - s_req=1; s_* payload stays stable (registered, independent of master inputs).
  - On s_gnt=1: capture s_rdata (0 for writes) into m_rdata, set s_req=0, go to RESP.
- RESP:
  - m_gnt[owner]=1 for exactly one cycle; s_req=0; rr_ptr = (owner+1) mod N_MASTERS; go to IDLE.
  - A new arbitration is never started from RESP, so s_req is low for at least 2 cycles between transactions and every transaction produces a fresh $rose(s_req).
- Latency:
  - m_req rises in cycle 0 → s_req high in cycle 1 → s_gnt earliest in cycle 2 → m_gnt in cycle 3.
  - Slave grant delay is 1..4 cycles after s_req rises.
- Outputs are registered; m_gnt is one-hot or zero.
- Each master must drop m_req in the cycle after its m_gnt. If it is still high, that is a new request, and it competes at the next IDLE at lowest priority.
- A master dropping m_req while it owns the bus is a protocol error. The transaction still completes and m_gnt still pulses.
- s_gnt while in IDLE or RESP is ignored.
- Simultaneous requests are resolved by round-robin only; there is no starvation. Worst-case wait is (N_MASTERS-1) transactions.
- m_rdata holds its value until the next RESP.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter is cleared on entry to REQ and increments each REQ cycle.
  - When the counter reaches TIMEOUT_CYCLES without s_gnt: s_req=0, go to RESP, m_gnt pulses, m_rdata=0, m_err=1.
  - On a normal completion m_err=0.
- Undefined:
  - No counter; REQ waits indefinitely for s_gnt.
  - m_err is tied to 0; the port always exists.

Decomposition:
- design_params_pkg gains:
  - arb_state_t enum {IDLE, REQ, RESP};
  - P_ARB_N_MASTERS default constant;
  - P_ARB_TIMEOUT default constant.
- One sub-module, timer_rr_pick: combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and a valid flag.
- The FSM, payload mux/latch and counter stay in timer_bus_arbiter.

Test Plan:
- Single read: m_req=01, m_addr[0]=P_ADDR_STATUS, slave s_gnt 2 cycles after s_req, s_rdata=0x5A → s_req high in cycle 1, m_gnt=01 in cycle 4, m_rdata=0x5A, m_err=0.
- Contention: m_req=11 held continuously from reset → grants alternate 01,10,01,10; each s_req rise is preceded by at least 2 low cycles.
- Write pass-through: master 1 writes 0x1234 to P_ADDR_LOAD → s_write_en=1, s_wdata=0x1234, s_addr stable until s_gnt; m_gnt=10.
- Reset mid-transaction: assert reset while in REQ → s_req and m_gnt are 0 immediately; after release, m_req=10 is granted to master 1 first (rr_ptr=0, master 0 idle).
- Timeout (ARB_TIMEOUT_EN): s_gnt held at 0 → s_req drops after 8 REQ cycles; m_gnt pulses with m_err=1 and m_rdata=0.
- Payload stability: master changes m_addr during REQ → s_addr unchanged until RESP.
